dll_acknak_decoder: RTL

Receive-side Ack/Nak DLLP decoder for the data link layer. It captures DLLPs from the RX path and checks their CRC-16. It validates each sequence number against the outstanding-TLP window and emits a one-cycle Ack/Nak event to the retry monitor, which uses that event to update AS, restart replay and reset its timeout.

---
 rtl/dll_acknak_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dll_acknak_decoder.sv
// Receive-side Ack/Nak DLLP decoder: capture + CRC stage, then window check and Ack/Nak event stage.
// Optional CRC checking is built when DLL_ACKNAK_CRC_CHECK_EN is defined.
module dll_acknak_decoder #(
  parameter int unsigned SEQ_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 sclk,
  input  logic                 srst_n,
  input  logic [47:0]          dllp_i,
  input  logic                 dllp_valid_i,
  input  logic [SEQ_WIDTH-1:0] next_tx_seq_i,
  output logic [SEQ_WIDTH-1:0] acknak_seq_num_o,
  output logic [1:0]           acknak_seq_en_o,
  output logic [CNT_WIDTH-1:0] crc_err_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic                 protocol_err_o
);

  localparam logic [7:0] TYPE_ACK = 8'h00;
  localparam logic [7:0] TYPE_NAK = 8'h10;
  localparam logic [1:0] EV_IDLE  = 2'b00;
  localparam logic [1:0] EV_ACK   = 2'b01;
  localparam logic [1:0] EV_NAK   = 2'b10;

  typedef enum logic {S_NORMAL, S_NAK_HOLD} state_t;

  logic                 crc_ok_c;
  logic                 s1_vld_q;
  logic [7:0]           s1_type_q;
  logic [SEQ_WIDTH-1:0] s1_seq_q;
  logic                 s1_crc_ok_q;

  state_t               state_q, state_d;
  logic [SEQ_WIDTH-1:0] as_q, as_d;
  logic [1:0]           en_q, en_d;
  logic [SEQ_WIDTH-1:0] num_q, num_d;
  logic                 perr_q, perr_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 crc_inc;
  logic [SEQ_WIDTH-1:0] diff_lo, diff_hi;
  logic                 in_win, is_ack, is_nak, dup;

`ifdef DLL_ACKNAK_CRC_CHECK_EN
  logic [CNT_WIDTH-1:0] crc_cnt_q, crc_cnt_d;
  logic [7:0]           unused_rsvd;

  // Serial CRC-16 (poly 0x100B), bit 0 first, seeded with all ones, inverted result
  function automatic logic [15:0] crc16_f(input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h100B;
    end
    return ~c;
  endfunction

  assign crc_ok_c    = (crc16_f(dllp_i[31:0]) == dllp_i[47:32]);
  assign unused_rsvd = dllp_i[15:8];

  always_comb begin
    crc_cnt_d = crc_cnt_q;
    if (crc_inc && (crc_cnt_q != '1)) crc_cnt_d = crc_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) crc_cnt_q <= '0;
    else         crc_cnt_q <= crc_cnt_d;
  end

  assign crc_err_cnt_o = crc_cnt_q;
`else
  logic [24:0] unused_bits;

  assign crc_ok_c      = 1'b1;
  assign unused_bits   = {dllp_i[47:32], dllp_i[15:8], crc_inc};
  assign crc_err_cnt_o = '0;
`endif

  // Stage 1: capture the DLLP fields and its CRC verdict
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      s1_vld_q    <= 1'b0;
      s1_type_q   <= '0;
      s1_seq_q    <= '0;
      s1_crc_ok_q <= 1'b0;
    end else begin
      s1_vld_q <= dllp_valid_i;
      if (dllp_valid_i) begin
        s1_type_q   <= dllp_i[7:0];
        s1_seq_q    <= dllp_i[16 +: SEQ_WIDTH];
        s1_crc_ok_q <= crc_ok_c;
      end
    end
  end

  // Window: S not behind AS and not beyond the last transmitted sequence number
  assign diff_lo = s1_seq_q - as_q;
  assign diff_hi = next_tx_seq_i - SEQ_WIDTH'(1) - s1_seq_q;
  assign in_win  = !diff_lo[SEQ_WIDTH-1] && !diff_hi[SEQ_WIDTH-1];
  assign is_ack  = (s1_type_q == TYPE_ACK);
  assign is_nak  = (s1_type_q == TYPE_NAK);
  assign dup     = (s1_seq_q == as_q);

  // Stage 2: next-state, AS update and event decision
  always_comb begin
    state_d = state_q;
    as_d    = as_q;
    en_d    = EV_IDLE;
    num_d   = num_q;
    perr_d  = 1'b0;
    drop_d  = drop_q;
    crc_inc = 1'b0;
    if (s1_vld_q) begin
      if (!s1_crc_ok_q) begin
        crc_inc = 1'b1;
      end else if (is_ack || is_nak) begin
        if (!in_win) begin
          perr_d = 1'b1;
          if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
        end else if (is_ack) begin
          if (dup) begin
            if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
          end else begin
            en_d    = EV_ACK;
            num_d   = s1_seq_q;
            as_d    = s1_seq_q;
            state_d = S_NORMAL;
          end
        end else if ((state_q == S_NAK_HOLD) && dup) begin
          if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
        end else begin
          en_d    = EV_NAK;
          num_d   = s1_seq_q;
          as_d    = s1_seq_q;
          state_d = S_NAK_HOLD;
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= S_NORMAL;
      as_q    <= '1;
      en_q    <= EV_IDLE;
      num_q   <= '0;
      perr_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      as_q    <= as_d;
      en_q    <= en_d;
      num_q   <= num_d;
      perr_q  <= perr_d;
      drop_q  <= drop_d;
    end
  end

  assign acknak_seq_en_o  = en_q;
  assign acknak_seq_num_o = num_q;
  assign protocol_err_o   = perr_q;
  assign drop_cnt_o       = drop_q;

endmodule
